// File: rtl/seq_pkg.sv
// Shared state encoding and pattern-mode constants for the LED pattern sequencer.
// ST_PAUSED is only reachable when SEQ_PAUSE_EN is defined.
`timescale 1ns/1ps
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DONE   = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    localparam logic [1:0] MODE_WALK = 2'd0;
    localparam logic [1:0] MODE_FILL = 2'd1;
    localparam logic [1:0] MODE_ALT  = 2'd2;
    localparam logic [1:0] MODE_INV  = 2'd3;

endpackage

// File: rtl/rise_edge_detect.sv
// Single-flop rising-edge detector producing a one-cycle pulse in the clk domain.
// RESET_VAL=1 suppresses a false pulse when the input is already high as reset releases.
`timescale 1ns/1ps
module rise_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= RESET_VAL;
        end else begin
            sig_q <= sig;
        end
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps animated LED frames on rising edges of a slow step input, counting passes until done.
// Optional pause input and PAUSED state are enabled by defining SEQ_PAUSE_EN.
`timescale 1ns/1ps
module led_pattern_sequencer
    import seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEPS  = 8,
    parameter int REPEAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_in,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [1:0]       mode,
`ifdef SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] leds,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    localparam int IDX_W  = $clog2(STEPS);
    localparam int PASS_W = (REPEAT > 0) ? $clog2(REPEAT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

    // Frame bits beyond the defined pattern stay zero; fill is built one bit wider so idx=WIDTH-1 lights all LEDs.
    function automatic logic [WIDTH-1:0] frame(input logic [1:0] m, input logic [IDX_W-1:0] i);
        logic [WIDTH-1:0] f;
        f = '0;
        case (m)
            MODE_WALK: f = WIDTH'(1) << i;
            MODE_FILL: f = WIDTH'(((WIDTH+1)'(1) << (int'(i) + 1)) - (WIDTH+1)'(1));
            MODE_ALT: begin
                for (int b = 0; b < WIDTH; b++) begin
                    f[b] = ((b % 2) == 1) ^ i[0];
                end
            end
            default: f = ~(WIDTH'(1) << i);
        endcase
        return f;
    endfunction

    logic step_pulse;

    rise_edge_detect #(
        .RESET_VAL(1'b1)
    ) u_step_edge (
        .clk  (clk),
        .reset(reset),
        .sig  (step_in),
        .pulse(step_pulse)
    );

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [PASS_W-1:0] pass, pass_n;
    logic [1:0]        mode_q, mode_n;
    logic              dir_q, dir_n;
    logic [WIDTH-1:0]  leds_n;
    logic              wrap_n, done_n, busy_n;
    logic              restart, advance, at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            pass   <= '0;
            mode_q <= MODE_WALK;
            dir_q  <= 1'b0;
            leds   <= '0;
            busy   <= 1'b0;
            wrap   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            pass   <= pass_n;
            mode_q <= mode_n;
            dir_q  <= dir_n;
            leds   <= leds_n;
            busy   <= busy_n;
            wrap   <= wrap_n;
            done   <= done_n;
        end
    end

    // Request priority is stop > start > pause > step; a restart discards progress without wrap/done.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        pass_n  = pass;
        mode_n  = mode_q;
        dir_n   = dir_q;
        leds_n  = leds;
        wrap_n  = 1'b0;
        done_n  = 1'b0;
        restart = 1'b0;
        advance = 1'b0;
        at_last = dir_q ? (idx == '0) : (idx == LAST_IDX);

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) restart = 1'b1;
            end
            ST_RUN: begin
                if (stop) begin
                    state_n = ST_IDLE;
                    leds_n  = '0;
                end else if (start) begin
                    restart = 1'b1;
`ifdef SEQ_PAUSE_EN
                end else if (pause) begin
                    state_n = ST_PAUSED;
`endif
                end else if (step_pulse) begin
                    advance = 1'b1;
                end
            end
`ifdef SEQ_PAUSE_EN
            ST_PAUSED: begin
                if (stop) begin
                    state_n = ST_IDLE;
                    leds_n  = '0;
                end else if (start) begin
                    restart = 1'b1;
                end else if (pause) begin
                    state_n = ST_RUN;
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
                leds_n  = '0;
            end
        endcase

        if (restart) begin
            state_n = ST_RUN;
            mode_n  = mode;
            dir_n   = dir;
            pass_n  = '0;
            idx_n   = dir ? LAST_IDX : '0;
            leds_n  = frame(mode, idx_n);
        end

        if (advance) begin
            if (at_last) begin
                idx_n  = dir_q ? LAST_IDX : '0;
                wrap_n = 1'b1;
                if (REPEAT != 0 && int'(pass) + 1 == REPEAT) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                    leds_n  = '0;
                end else begin
                    if (REPEAT != 0) pass_n = pass + PASS_W'(1);
                    leds_n = frame(mode_q, idx_n);
                end
            end else begin
                idx_n  = dir_q ? idx - IDX_W'(1) : idx + IDX_W'(1);
                leds_n = frame(mode_q, idx_n);
            end
        end

        busy_n = (state_n == ST_RUN);
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized self-checking bench for led_pattern_sequencer against a position/pass based reference model.
// Pause scenarios are exercised only when SEQ_PAUSE_EN is defined.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

    localparam int WIDTH  = 8;
    localparam int STEPS  = 8;
    localparam int REPEAT = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             step_in;
    logic             start;
    logic             stop;
    logic             dir;
    logic [1:0]       mode;
`ifdef SEQ_PAUSE_EN
    logic             pause;
`endif
    logic [WIDTH-1:0] leds;
    logic             busy;
    logic             wrap;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 idle, 1 run, 2 done, 3 paused; m_pos counts steps taken within the current pass.
    int m_state = 0;
    int m_mode  = 0;
    int m_dir   = 0;
    int m_pos   = 0;
    int m_pass  = 0;
    bit exp_wrap = 1'b0;
    bit exp_done = 1'b0;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .WIDTH (WIDTH),
        .STEPS (STEPS),
        .REPEAT(REPEAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .step_in(step_in),
        .start  (start),
        .stop   (stop),
        .dir    (dir),
        .mode   (mode),
`ifdef SEQ_PAUSE_EN
        .pause  (pause),
`endif
        .leds   (leds),
        .busy   (busy),
        .wrap   (wrap),
        .done   (done)
    );

    function automatic logic [7:0] ref_frame(input int md, input int ix);
        case (md)
            0:       return 8'((1 << ix) & 255);
            1:       return 8'(((1 << (ix + 1)) - 1) & 255);
            2:       return ((ix % 2) == 0) ? 8'hAA : 8'h55;
            default: return 8'(~(1 << ix) & 255);
        endcase
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [7:0] l;
        int ix;
        ix = (m_dir != 0) ? (STEPS - 1 - m_pos) : m_pos;
        l = (m_state == 1 || m_state == 3) ? ref_frame(m_mode, ix) : 8'h00;
        return {l, (m_state == 1), exp_wrap, exp_done};
    endfunction

    task automatic drive_start(input int md, input int dr, input bit with_stop);
        start = 1'b1;
        stop  = with_stop;
        mode  = 2'(md);
        dir   = dr[0];
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        exp_wrap = 1'b0;
        exp_done = 1'b0;
        if (with_stop && (m_state == 1 || m_state == 3)) begin
            m_state = 0;
        end else begin
            m_state = 1;
            m_mode  = md;
            m_dir   = dr;
            m_pos   = 0;
            m_pass  = 0;
        end
    endtask

    task automatic drive_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        exp_wrap = 1'b0;
        exp_done = 1'b0;
        if (m_state == 1 || m_state == 3) m_state = 0;
    endtask

    // Rising edge on step_in; mode/dir inputs are scrambled to show they are ignored mid-run.
    task automatic drive_step();
        step_in = 1'b1;
        mode    = 2'($urandom_range(0, 3));
        dir     = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp_wrap = 1'b0;
        exp_done = 1'b0;
        if (m_state == 1) begin
            m_pos++;
            if (m_pos == STEPS) begin
                m_pos    = 0;
                exp_wrap = 1'b1;
                m_pass++;
                if (REPEAT != 0 && m_pass == REPEAT) begin
                    m_state  = 2;
                    exp_done = 1'b1;
                end
            end
        end
    endtask

    task automatic step_release();
        repeat (2) @(negedge clk);
        step_in = 1'b0;
        repeat ($urandom_range(2, 5)) @(negedge clk);
        exp_wrap = 1'b0;
        exp_done = 1'b0;
    endtask

`ifdef SEQ_PAUSE_EN
    task automatic drive_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        if (m_state == 1) m_state = 3;
        else if (m_state == 3) m_state = 1;
    endtask
`endif

    task automatic test_reset();
        logic [10:0] obs, exp;
        reset   = 1'b1;
        step_in = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        dir     = 1'b0;
        mode    = 2'd0;
`ifdef SEQ_PAUSE_EN
        pause   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (dut.step_pulse !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_no_false_pulse: got step_pulse=%b, expected 0", dut.step_pulse);
        end
        for (int c = 0; c < 2; c++) begin
            obs = {leds, busy, wrap, done};
            exp = exp_vec();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs cycle%0d: got leds=%h bwd=%b, expected leds=%h bwd=%b", c, obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
            end
            @(negedge clk);
        end
        step_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_walk_up();
        logic [10:0] obs, exp;
        drive_start(0, 0, 1'b0);
        obs = {leds, busy, wrap, done};
        n_checks++;
        if (obs !== {8'h01, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL walk_start: got leds=%h bwd=%b, expected leds=01 bwd=100", obs[10:3], obs[2:0]);
        end
        for (int s = 1; s <= STEPS; s++) begin
            drive_step();
            obs = {leds, busy, wrap, done};
            exp = exp_vec();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL walk_step%0d: got leds=%h bwd=%b, expected leds=%h bwd=%b", s, obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
            end
            step_release();
            obs = {leds, busy, wrap, done};
            exp = exp_vec();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL walk_hold%0d: got leds=%h bwd=%b, expected leds=%h bwd=%b", s, obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
            end
        end
    endtask

    task automatic test_completion();
        logic [10:0] obs, exp;
        for (int s = 1; s <= STEPS + 2; s++) begin
            drive_step();
            obs = {leds, busy, wrap, done};
            exp = exp_vec();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL complete_step%0d: got leds=%h bwd=%b, expected leds=%h bwd=%b", s, obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
            end
            if (s == STEPS) begin
                n_checks++;
                if (obs !== {8'h00, 3'b011}) begin
                    n_fail++;
                    $display("[TB] FAIL complete_done_pulse: got leds=%h bwd=%b, expected leds=00 bwd=011", obs[10:3], obs[2:0]);
                end
                @(negedge clk);
                exp_wrap = 1'b0;
                exp_done = 1'b0;
                obs = {leds, busy, wrap, done};
                n_checks++;
                if (obs !== {8'h00, 3'b000}) begin
                    n_fail++;
                    $display("[TB] FAIL complete_pulse_width: got leds=%h bwd=%b, expected leds=00 bwd=000", obs[10:3], obs[2:0]);
                end
            end
            step_release();
        end
    endtask

    task automatic test_fill_down();
        logic [10:0] obs, exp;
        drive_start(1, 1, 1'b0);
        obs = {leds, busy, wrap, done};
        n_checks++;
        if (obs !== {8'hFF, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL fill_down_start: got leds=%h bwd=%b, expected leds=ff bwd=100", obs[10:3], obs[2:0]);
        end
        for (int s = 1; s <= 3; s++) begin
            drive_step();
            obs = {leds, busy, wrap, done};
            exp = exp_vec();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL fill_down_step%0d: got leds=%h bwd=%b, expected leds=%h bwd=%b", s, obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
            end
            step_release();
        end
    endtask

    task automatic test_start_stop_same();
        logic [10:0] obs;
        drive_start(2, 0, 1'b0);
        drive_step();
        step_release();
        drive_start(1, 1, 1'b1);
        obs = {leds, busy, wrap, done};
        n_checks++;
        if (obs !== {8'h00, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL start_stop_same: got leds=%h bwd=%b, expected leds=00 bwd=000", obs[10:3], obs[2:0]);
        end
    endtask

    task automatic test_start_with_step();
        logic [10:0] obs, exp;
        drive_start(3, 0, 1'b0);
        for (int s = 0; s < STEPS - 1; s++) begin
            drive_step();
            step_release();
        end
        step_in = 1'b1;
        drive_start(3, 0, 1'b0);
        obs = {leds, busy, wrap, done};
        n_checks++;
        if (obs !== {8'hFE, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL start_with_step: got leds=%h bwd=%b, expected leds=fe bwd=100", obs[10:3], obs[2:0]);
        end
        step_release();
        drive_step();
        obs = {leds, busy, wrap, done};
        exp = exp_vec();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL start_with_step_next: got leds=%h bwd=%b, expected leds=%h bwd=%b", obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
        end
        step_release();
    endtask

    task automatic test_random();
        logic [10:0] obs, exp;
        int n;
        for (int it = 0; it < 10; it++) begin
            drive_start($urandom_range(0, 3), $urandom_range(0, 1), 1'b0);
            obs = {leds, busy, wrap, done};
            exp = exp_vec();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL random%0d_start: got leds=%h bwd=%b, expected leds=%h bwd=%b", it, obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
            end
            n = $urandom_range(1, 20);
            for (int s = 0; s < n; s++) begin
                drive_step();
                obs = {leds, busy, wrap, done};
                exp = exp_vec();
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL random%0d_step%0d: got leds=%h bwd=%b, expected leds=%h bwd=%b", it, s, obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
                end
                step_release();
                if ($urandom_range(0, 15) == 0) begin
                    drive_stop();
                    obs = {leds, busy, wrap, done};
                    exp = exp_vec();
                    n_checks++;
                    if (obs !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL random%0d_stop: got leds=%h bwd=%b, expected leds=%h bwd=%b", it, obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
                    end
                end
            end
        end
    endtask

`ifdef SEQ_PAUSE_EN
    task automatic test_pause();
        logic [10:0] obs, exp;
        drive_start(0, 0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            drive_step();
            step_release();
        end
        drive_pause();
        obs = {leds, busy, wrap, done};
        n_checks++;
        if (obs !== {8'h08, 3'b000}) begin
            n_fail++;
            $display("[TB] FAIL pause_enter: got leds=%h bwd=%b, expected leds=08 bwd=000", obs[10:3], obs[2:0]);
        end
        for (int s = 0; s < 5; s++) begin
            drive_step();
            obs = {leds, busy, wrap, done};
            exp = exp_vec();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL pause_hold%0d: got leds=%h bwd=%b, expected leds=%h bwd=%b", s, obs[10:3], obs[2:0], exp[10:3], exp[2:0]);
            end
            step_release();
        end
        drive_pause();
        drive_step();
        obs = {leds, busy, wrap, done};
        n_checks++;
        if (obs !== {8'h10, 3'b100}) begin
            n_fail++;
            $display("[TB] FAIL pause_resume: got leds=%h bwd=%b, expected leds=10 bwd=100", obs[10:3], obs[2:0]);
        end
        step_release();
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_walk_up();
        test_completion();
        test_fill_down();
        test_start_stop_same();
        test_start_with_step();
        test_random();
`ifdef SEQ_PAUSE_EN
        test_pause();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
